// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 RISC-V integer register file fed by writeback, with 1-cycle synchronous reads.
// Optional same-edge writeback-to-read bypass is enabled by defining RF_WRITE_BYPASS_EN.
module reg_file_wb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned IDXW  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            regWrite,
   input  logic [IDXW-1:0] rd,
   input  logic [XLEN-1:0] dataToReg,
   input  logic            stall,
   input  logic [IDXW-1:0] rs1,
   input  logic [IDXW-1:0] rs2,
   output logic [XLEN-1:0] rs1Data,
   output logic [XLEN-1:0] rs2Data,
   output logic            ready
);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREGS - 1);
   localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDXW-1:0] r_clr_idx;
   logic [XLEN-1:0] r_mem [NREGS];
   logic            r_ready;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;

   logic            w_we;
   logic [IDXW-1:0] w_waddr;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;

   // Next state and array write port: clear sequencer owns the port during INIT.
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_waddr     = rd;
      w_wdata     = dataToReg;
      case (r_state)
         ST_INIT: begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = '0;
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            w_we = regWrite && (rd != '0);
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // Read-port values; x0 is hardwired to zero and never bypassed.
   always_comb begin
      w_rs1_val = (rs1 == '0) ? '0 : r_mem[rs1];
      w_rs2_val = (rs2 == '0) ? '0 : r_mem[rs2];
`ifdef RF_WRITE_BYPASS_EN
      if ((r_state == ST_READY) && regWrite && (rd != '0)) begin
         if (rd == rs1) begin
            w_rs1_val = dataToReg;
         end
         if (rd == rs2) begin
            w_rs2_val = dataToReg;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_INIT;
         r_clr_idx  <= FIRST_IDX;
         r_ready    <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == ST_READY);
         if ((r_state == ST_INIT) && (r_clr_idx != LAST_IDX)) begin
            r_clr_idx <= r_clr_idx + IDXW'(1);
         end
         if (r_state != ST_READY) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
         end else if (!stall) begin
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
         end
      end
   end

   // Storage array carries no reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   assign rs1Data = r_rs1_data;
   assign rs2Data = r_rs2_data;
   assign ready   = r_ready;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: scoreboard of expected read data against a reference model.
// Honours RF_WRITE_BYPASS_EN to select the expected same-cycle hazard behaviour.
module tb_reg_file_wb;

`ifdef RF_WRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        regWrite;
   logic [4:0]  rd;
   logic [31:0] dataToReg;
   logic        stall;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        ready;

   int          n_tests;
   int          n_fail;
   logic [31:0] mem [32];
   logic [31:0] held1;
   logic [31:0] held2;
   logic [31:0] exp1_q[$];
   logic [31:0] exp2_q[$];

   reg_file_wb dut (
      .clk       (clk),
      .reset     (reset),
      .regWrite  (regWrite),
      .rd        (rd),
      .dataToReg (dataToReg),
      .stall     (stall),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1Data   (rs1Data),
      .rs2Data   (rs2Data),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_rd(input logic [4:0] a, input logic we,
                                            input logic [4:0] w_rd, input logic [31:0] d);
      if (a == 5'd0) return 32'h0;
      if (BYPASS && we && (w_rd == a)) return d;
      return mem[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      held1 = 32'h0;
      held2 = 32'h0;
   endtask

   // Drive one READY-state cycle at the falling edge, record expected reads, wait past the edge.
   task automatic issue(input logic we, input logic [4:0] w_rd, input logic [31:0] d,
                        input logic st, input logic [4:0] a1, input logic [4:0] a2);
      logic [31:0] x1, x2;
      @(negedge clk);
      regWrite = we; rd = w_rd; dataToReg = d; stall = st; rs1 = a1; rs2 = a2;
      if (st) begin
         x1 = held1;
         x2 = held2;
      end else begin
         x1 = model_rd(a1, we, w_rd, d);
         x2 = model_rd(a2, we, w_rd, d);
      end
      held1 = x1;
      held2 = x2;
      exp1_q.push_back(x1);
      exp2_q.push_back(x2);
      if (we && (w_rd != 5'd0)) mem[w_rd] = d;
      @(posedge clk);
      #1;
      regWrite = 1'b0;
   endtask

   task automatic test_reset();
      int          edge_rdy;
      logic [31:0] e1, e2;
      reset = 1'b0; regWrite = 1'b0; rd = '0; dataToReg = '0; stall = 1'b0; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (rs1Data !== 32'h0 || rs2Data !== 32'h0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state rs1Data=%h rs2Data=%h ready=%b required 0/0/0", rs1Data, rs2Data, ready);
      end
      @(negedge clk);
      reset = 1'b1;
      edge_rdy = 0;
      for (int e = 1; e <= 40 && edge_rdy == 0; e++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) edge_rdy = e;
      end
      n_tests++;
      if (edge_rdy != 31) begin
         n_fail++;
         $display("FAIL ready_latency got edge %0d required edge 31", edge_rdy);
      end
      model_clear();
      for (int i = 1; i <= 31; i++) begin
         issue(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(32 - i));
         e1 = exp1_q.pop_front();
         e2 = exp2_q.pop_front();
         n_tests++;
         if (rs1Data !== e1 || rs2Data !== e2) begin
            n_fail++;
            $display("FAIL clear_read x%0d rs1Data=%h rs2Data=%h required %h/%h", i, rs1Data, rs2Data, e1, e2);
         end
      end
   endtask

   task automatic test_basic_x0();
      logic [31:0] e1, e2;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
            1: issue(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0);
            2: issue(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd5);
            3: issue(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
            default: issue(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5);
         endcase
         e1 = exp1_q.pop_front();
         e2 = exp2_q.pop_front();
         n_tests++;
         if (rs1Data !== e1 || rs2Data !== e2) begin
            n_fail++;
            $display("FAIL basic_x0 step %0d rs1Data=%h rs2Data=%h required %h/%h", k, rs1Data, rs2Data, e1, e2);
         end
      end
   endtask

   task automatic test_hazard();
      logic [31:0] e1, e2;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: issue(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
            1: issue(1'b1, 5'd7, 32'h22222222, 1'b0, 5'd7, 5'd7);
            default: issue(1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 5'd0);
         endcase
         e1 = exp1_q.pop_front();
         e2 = exp2_q.pop_front();
         n_tests++;
         if (rs1Data !== e1 || rs2Data !== e2) begin
            n_fail++;
            $display("FAIL hazard step %0d rs1Data=%h rs2Data=%h required %h/%h", k, rs1Data, rs2Data, e1, e2);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] e1, e2;
      for (int k = 0; k < 7; k++) begin
         if (k == 0)      issue(1'b1, 5'd9, 32'h0000ABCD, 1'b0, 5'd0, 5'd0);
         else if (k == 1) issue(1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd0);
         else if (k < 6)  issue(1'b1, 5'(8 + k), 32'h12345678, 1'b1, 5'(8 + k), 5'd9);
         else             issue(1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 5'd10);
         e1 = exp1_q.pop_front();
         e2 = exp2_q.pop_front();
         n_tests++;
         if (rs1Data !== e1 || rs2Data !== e2) begin
            n_fail++;
            $display("FAIL stall step %0d rs1Data=%h rs2Data=%h required %h/%h", k, rs1Data, rs2Data, e1, e2);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1, e2;
      logic [4:0]  w_rd, a1, a2;
      for (int k = 0; k < 60; k++) begin
         w_rd = 5'($urandom_range(0, 31));
         a1   = ($urandom_range(0, 2) == 0) ? w_rd : 5'($urandom_range(0, 31));
         a2   = 5'($urandom_range(0, 31));
         issue(1'($urandom_range(0, 1)), w_rd, $urandom, ($urandom_range(0, 3) == 0), a1, a2);
         e1 = exp1_q.pop_front();
         e2 = exp2_q.pop_front();
         n_tests++;
         if (rs1Data !== e1 || rs2Data !== e2) begin
            n_fail++;
            $display("FAIL back_to_back step %0d rs1Data=%h rs2Data=%h required %h/%h", k, rs1Data, rs2Data, e1, e2);
         end
      end
   endtask

   task automatic test_reset_mid();
      int          edge_rdy;
      logic [31:0] e1, e2;
      issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd13, 5'd9);
      void'(exp1_q.pop_front());
      void'(exp2_q.pop_front());
      // Assert reset between edges while READY with non-zero outputs.
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (rs1Data !== 32'h0 || rs2Data !== 32'h0 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_ready rs1Data=%h rs2Data=%h ready=%b required 0/0/0", rs1Data, rs2Data, ready);
      end
      @(negedge clk);
      reset = 1'b1;
      regWrite = 1'b1; rd = 5'd3; dataToReg = 32'hAAAA5555; stall = 1'b0; rs1 = 5'd13; rs2 = 5'd3;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (rs1Data !== 32'h0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_read edge %0d rs1Data=%h ready=%b required 0/0", e, rs1Data, ready);
         end
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (ready !== 1'b0 || rs1Data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_init ready=%b rs1Data=%h required 0/0", ready, rs1Data);
      end
      @(negedge clk);
      reset = 1'b1;
      edge_rdy = 0;
      for (int e = 1; e <= 40 && edge_rdy == 0; e++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) edge_rdy = e;
         n_tests++;
         if (rs1Data !== 32'h0) begin
            n_fail++;
            $display("FAIL init_read2 edge %0d rs1Data=%h required 0", e, rs1Data);
         end
         @(negedge clk);
         regWrite = (edge_rdy == 0);
      end
      regWrite = 1'b0;
      n_tests++;
      if (edge_rdy != 31) begin
         n_fail++;
         $display("FAIL ready_latency2 got edge %0d required edge 31", edge_rdy);
      end
      model_clear();
      issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd13);
      e1 = exp1_q.pop_front();
      e2 = exp2_q.pop_front();
      n_tests++;
      if (rs1Data !== e1 || rs2Data !== e2) begin
         n_fail++;
         $display("FAIL init_write_drop rs1Data=%h rs2Data=%h required %h/%h", rs1Data, rs2Data, e1, e2);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_clear();
      test_reset();
      test_basic_x0();
      test_hazard();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32x32 RISC-V integer register file. It is the consumer end of the writeback interface: it accepts dataToReg/regWrite/rd from the writeback stage and serves the two source-operand reads for decode.
- Synchronous read ports with one-cycle latency and a decode-stall hold.
- Post-reset hardware clear sequencer zeroes x1..x31 so the array needs no reset.
- Sits between the writeback latch and the decode/execute latch.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (x0..x31); must be 32.
- IDXW, 5, register index width; must equal log2(NREGS).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- regWrite  input  1  write enable from writeback.
- rd  input  IDXW  destination register index.
- dataToReg  input  XLEN  write data.
- stall  input  1  decode stall; read outputs hold while high.
- rs1  input  IDXW  read port 1 index.
- rs2  input  IDXW  read port 2 index.
- rs1Data  output  XLEN  registered read data, port 1.
- rs2Data  output  XLEN  registered read data, port 2.
- ready  output  1  high once the clear sequence is done; pipeline must not issue before.

Behaviour:
- Reset (reset=0, async):
  - state=INIT, clrIdx=1.
  - rs1Data=0, rs2Data=0, ready=0.
  - Array contents are not reset.
- FSM state INIT:
  - Each cycle writes 0 to array[clrIdx], then clrIdx increments.
  - When clrIdx==31 is written, the next state is READY.
  - Exactly 31 clock edges after reset release, ready=1.
- FSM state READY:
  - Terminal state; left only by reset.
  - ready is registered and is 1 in this state.
- Writes, READY only:
  - If regWrite=1 and rd!=0, array[rd] <= dataToReg at the rising edge.
  - rd==0 writes are discarded.
  - regWrite during INIT is dropped; upstream is held by ready=0.
- Reads:
  - At each rising edge with stall=0: rs1Data <= value(rs1), rs2Data <= value(rs2). Latency is 1 cycle.
  - stall=1: rs1Data and rs2Data hold their values; writes still occur.
  - Index 0 always reads 0, regardless of array content.
  - During INIT, read outputs load 0.
- Same-cycle write/read to the same index:
  - Behaviour is governed by the optional feature below.
- Both ports may read the same index simultaneously; they return identical data.
- Reset asserted mid-INIT or mid-READY: outputs clear immediately and the clear sequence restarts from clrIdx=1.
- clrIdx is IDXW bits; no wrap occurs, because the FSM exits before overflow.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined:
  - When stall=0, regWrite=1, ready=1 and rd==rsN!=0, rsNData loads dataToReg in the same edge as the array write.
  - A writeback is therefore visible to decode the very next cycle.
- Undefined:
  - rsNData loads the pre-write array value (old data).
  - The pipeline must cover the hazard by stalling one extra cycle.
- x0 is never bypassed in either configuration.

Test Plan:
- Reset clear sequence:
  - Stimulus: hold reset=0 for 3 cycles, release. Poll ready; then read x1..x31 via rs1/rs2.
  - Required response: ready rises exactly 31 edges after release, and every read returns 0x00000000.
- Basic write/read:
  - Stimulus: write rd=5 with 0xDEADBEEF; next cycle rs1=5, rs2=0.
  - Required response: one cycle later rs1Data=0xDEADBEEF and rs2Data=0.
- x0 protection:
  - Stimulus: write rd=0 with 0xFFFFFFFF; read rs1=0.
  - Required response: rs1Data=0.
- Same-cycle hazard:
  - Stimulus: x7=0x11111111; then in the same cycle write rd=7 with 0x22222222 and read rs1=7.
  - Required response: rs1Data=0x22222222 with RF_WRITE_BYPASS_EN defined, 0x11111111 without it; the following read returns 0x22222222 in both builds.
- Stall hold:
  - Stimulus: rs1Data=0x0000ABCD; assert stall for 4 cycles while changing rs1 and writing rd=rs1 with 0x12345678.
  - Required response: rs1Data stays 0x0000ABCD throughout; after stall drops, reading that register returns 0x12345678.
- Reset mid-INIT:
  - Stimulus: release reset, wait 10 cycles, assert reset=0 asynchronously between edges, release again.
  - Required response: ready=0 immediately; ready rises 31 edges after the second release; regWrite pulses issued during INIT leave their registers at 0.
